// File: rtl/chromosome_eval_sequencer.sv
// Sequences one fitness evaluation: clears the error-sum accumulator, steps the
// evaluated circuit through NUM_SEQUENCES clocked sequences, then reduces the masked sums.
module chromosome_eval_sequencer #(
    parameter int unsigned HALF_PERIOD   = 32,
    parameter int unsigned NUM_SEQUENCES = 16
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic [7:0]        iOutputMask,
    input  logic [7:0][31:0]  iErrorSums,
    output logic              oProcessing,
    output logic              oKeepResult,
    output logic              oClockLevel,
    output logic [3:0]        oCurrentSequence,
    output logic              oBusy,
    output logic              oDone,
    output logic [34:0]       oTotalError
);

    typedef enum logic [2:0] {IDLE, CLEAR, HIGH, LOW, SUM, DONE} state_t;

    localparam logic [15:0] PH_LAST  = 16'(HALF_PERIOD - 1);
    localparam logic [3:0]  SEQ_LAST = 4'(NUM_SEQUENCES - 1);

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [3:0]  seq_q, seq_d;
    logic [7:0]  mask_q, mask_d;
    logic [34:0] total_q, total_d;
    logic        proc_q, proc_d;
    logic        keep_q, keep_d;
    logic        clk_lvl_q, clk_lvl_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [34:0] masked_sum;

    always_comb begin
        masked_sum = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (mask_q[k]) masked_sum = masked_sum + {3'b000, iErrorSums[k]};
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        seq_d   = seq_q;
        mask_d  = mask_q;
        total_d = total_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (iStart) begin
                    state_d = CLEAR;
                    mask_d  = iOutputMask;
                end
            end
            CLEAR: begin
                if (iAbort) state_d = IDLE;
                else begin
                    state_d = HIGH;
                    phase_d = '0;
                    seq_d   = '0;
                end
            end
            HIGH: begin
                if (iAbort) state_d = IDLE;
                else if (phase_q == PH_LAST) begin
                    state_d = LOW;
                    phase_d = '0;
                end else phase_d = phase_q + 16'd1;
            end
            LOW: begin
                if (iAbort) state_d = IDLE;
                else if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (seq_q == SEQ_LAST) state_d = SUM;
                    else begin
                        state_d = HIGH;
                        seq_d   = seq_q + 4'd1;
                    end
                end else phase_d = phase_q + 16'd1;
            end
            SUM: begin
                if (iAbort) state_d = IDLE;
                else begin
                    state_d = DONE;
                    total_d = masked_sum;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            phase_d = '0;
            seq_d   = '0;
        end
        // Outputs are decoded from the next state so they register alongside it.
        proc_d    = (state_d == HIGH) || (state_d == LOW);
        clk_lvl_d = (state_d == HIGH);
        keep_d    = (state_d == SUM) || (state_d == DONE);
        busy_d    = (state_d == CLEAR) || (state_d == HIGH) || (state_d == LOW) || (state_d == SUM);
        done_d    = (state_q == SUM) && (state_d == DONE);
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            seq_q     <= '0;
            mask_q    <= '0;
            total_q   <= '0;
            proc_q    <= 1'b0;
            keep_q    <= 1'b0;
            clk_lvl_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            seq_q     <= seq_d;
            mask_q    <= mask_d;
            total_q   <= total_d;
            proc_q    <= proc_d;
            keep_q    <= keep_d;
            clk_lvl_q <= clk_lvl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign oProcessing      = proc_q;
    assign oKeepResult      = keep_q;
    assign oClockLevel      = clk_lvl_q;
    assign oCurrentSequence = seq_q;
    assign oBusy            = busy_q;
    assign oDone            = done_q;
    assign oTotalError      = total_q;

endmodule

// File: tb/tb_chromosome_eval_sequencer.sv
// Directed bench for chromosome_eval_sequencer with a behavioural error-sum accumulator.
module tb_chromosome_eval_sequencer;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, abort;
    logic [7:0]       mask;
    logic [7:0][31:0] err_sums;
    logic             proc, keep, clk_lvl, busy, done;
    logic [3:0]       seq;
    logic [34:0]      total;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0][31:0] acc;
    logic             force_all = 1'b0;
    logic [7:0]       circ_out = 8'h00;
    logic [7:0]       exp_out  = 8'hFF;

    always #5 clk = ~clk;

    chromosome_eval_sequencer #(.HALF_PERIOD(4), .NUM_SEQUENCES(16)) dut (
        .iClock(clk), .iReset_n(rst_n), .iStart(start), .iAbort(abort),
        .iOutputMask(mask), .iErrorSums(err_sums),
        .oProcessing(proc), .oKeepResult(keep), .oClockLevel(clk_lvl),
        .oCurrentSequence(seq), .oBusy(busy), .oDone(done), .oTotalError(total)
    );

    // Accumulator: zeroes while not keeping, counts one per mismatching output per processing cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (proc) begin
                if (circ_out[k] != exp_out[k]) acc[k] <= acc[k] + 32'd1;
            end else if (!keep) acc[k] <= '0;
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) err_sums[k] = force_all ? 32'hFFFF_FFFF : acc[k];
    end

    task automatic pulse_start(input logic [7:0] m);
        @(negedge clk);
        start = 1'b1;
        mask  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mask = 8'h00;
        @(negedge clk);
        n_checks++;
        if ({proc, keep, clk_lvl, seq, busy, done, total} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got proc=%b keep=%b clk=%b seq=%0d busy=%b done=%b total=%0h, want all 0",
                     proc, keep, clk_lvl, seq, busy, done, total);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_eval(input string name, input logic [7:0] m, input logic [34:0] want_total);
        int cnt = 0;
        pulse_start(m);
        n_checks++;
        if (!(busy === 1'b1 && keep === 1'b0 && proc === 1'b0)) begin
            n_fail++;
            $display("FAIL %s_clear: got busy=%b keep=%b proc=%b, want 1 0 0", name, busy, keep, proc);
        end
        while (done !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt != 130) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, want 130", name, cnt);
        end
        n_checks++;
        if (total !== want_total) begin
            n_fail++;
            $display("FAIL %s_total: got %0h, want %0h", name, total, want_total);
        end
        @(negedge clk);
        n_checks++;
        if (!(done === 1'b0 && keep === 1'b1 && total === want_total)) begin
            n_fail++;
            $display("FAIL %s_hold: got done=%b keep=%b total=%0h, want 0 1 %0h", name, done, keep, total, want_total);
        end
    endtask

    task automatic test_masks;
        run_eval("mask_ff", 8'hFF, 35'd1024);
        run_eval("mask_05", 8'h05, 35'd256);
        run_eval("mask_00", 8'h00, 35'd0);
    endtask

    task automatic test_no_wrap;
        force_all = 1'b1;
        run_eval("all_ones", 8'hFF, 35'h7_FFFF_FFF8);
        force_all = 1'b0;
    endtask

    task automatic test_abort;
        int cnt = 0;
        int seen_done = 0;
        pulse_start(8'hFF);
        while (!(seq === 4'd3) && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (!(proc === 1'b1 && busy === 1'b1 && seq === 4'd3)) begin
            n_fail++;
            $display("FAIL start_ignored: got proc=%b busy=%b seq=%0d, want 1 1 3", proc, busy, seq);
        end
        cnt = 0;
        while (!(seq === 4'd9 && clk_lvl === 1'b0) && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt >= 300) begin
            n_fail++;
            $display("FAIL abort_reach_seq9_low: timeout got seq=%0d clk=%b, want 9 0", seq, clk_lvl);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (!(busy === 1'b0 && proc === 1'b0 && keep === 1'b0 && seq === 4'd0 && done === 1'b0)) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b proc=%b keep=%b seq=%0d done=%b, want 0 0 0 0 0",
                     busy, proc, keep, seq, done);
        end
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done != 0 || total !== 35'h7_FFFF_FFF8) begin
            n_fail++;
            $display("FAIL abort_retain: got active_cycles=%0d total=%0h, want 0 7fffffff8", seen_done, total);
        end
    endtask

    task automatic test_waveform_back_to_back;
        int hold[16];
        int falls = 0;
        int proc_cycles = 0;
        int cnt = 0;
        logic prev_clk = 1'b0;
        for (int s = 0; s < 16; s++) hold[s] = 0;
        pulse_start(8'hFF);
        while (done !== 1'b1 && cnt < 300) begin
            if (prev_clk && !clk_lvl) falls++;
            prev_clk = clk_lvl;
            if (proc === 1'b1) begin
                proc_cycles++;
                hold[seq]++;
            end
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (falls != 16 || proc_cycles != 128) begin
            n_fail++;
            $display("FAIL wave_counts: got falls=%0d proc_cycles=%0d, want 16 128", falls, proc_cycles);
        end
        for (int s = 0; s < 16; s++) begin
            n_checks++;
            if (hold[s] != 8) begin
                n_fail++;
                $display("FAIL wave_hold_seq%0d: got %0d cycles, want 8", s, hold[s]);
            end
        end
        start = 1'b1;
        mask  = 8'h05;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (!(busy === 1'b1 && keep === 1'b0 && proc === 1'b0 && done === 1'b0)) begin
            n_fail++;
            $display("FAIL b2b_clear: got busy=%b keep=%b proc=%b done=%b, want 1 0 0 0", busy, keep, proc, done);
        end
        cnt = 0;
        while (done !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt != 130 || total !== 35'd256) begin
            n_fail++;
            $display("FAIL b2b_result: got latency=%0d total=%0h, want 130 100", cnt, total);
        end
    endtask

    task automatic test_reset_mid;
        int cnt = 0;
        pulse_start(8'hFF);
        while (!(seq === 4'd5 && clk_lvl === 1'b1) && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({proc, keep, clk_lvl, seq, busy, done, total} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got proc=%b keep=%b clk=%b seq=%0d busy=%b done=%b total=%0h, want all 0",
                     proc, keep, clk_lvl, seq, busy, done, total);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || proc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got busy=%b proc=%b, want 0 0", busy, proc);
        end
        run_eval("after_reset", 8'hFF, 35'd1024);
    endtask

    initial begin
        test_reset;
        test_masks;
        test_no_wrap;
        test_abort;
        test_waveform_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chromosome_eval_sequencer.md
# chromosome_eval_sequencer

Controller that runs one fitness evaluation of a candidate circuit by sequencing the chromosome error-sum accumulator. On a start request it clears the accumulator and steps through the 16 expected input sequences, driving the evaluated circuit's clock level with a fixed half-period for each. It then freezes the per-output error sums and reduces them to a single masked total error for the genetic-algorithm core. It sits between the GA control FSM and the error-sum datapath, and owns that datapath's iProcessing, iKeepResult, iClockLevel and iCurrentSequence inputs.

## Interface
- HALF_PERIOD, 32: cycles per clock-level phase, high then low; legal range 1..2^16-1
- NUM_SEQUENCES, 16: sequences per evaluation; legal range 1..16
- iClock  in  1  system clock, all state on rising edge
- iReset_n  in  1  asynchronous, active-low reset
- iStart  in  1  evaluation request; sampled only in IDLE or DONE
- iAbort  in  1  cancels an evaluation in progress
- iOutputMask  in  8  bit k set means output k counts toward the total; latched at start
- iErrorSums  in  8x32  per-output error sums from the accumulator
- oProcessing  out  1  to accumulator iProcessing
- oKeepResult  out  1  to accumulator iKeepResult
- oClockLevel  out  1  to accumulator iClockLevel and the evaluated circuit
- oCurrentSequence  out  4  to accumulator iCurrentSequence
- oBusy  out  1  high in CLEAR, HIGH, LOW and SUM
- oDone  out  1  one-cycle pulse when oTotalError is valid
- oTotalError  out  35  masked sum of iErrorSums, held until the next accepted start

## Operation
- States: IDLE, CLEAR, HIGH, LOW, SUM, DONE.
- Reset (any time, including mid-evaluation): state IDLE; all outputs 0; phase counter 0; latched mask 0.
- IDLE/DONE + iStart: latch iOutputMask, go to CLEAR. oKeepResult is 0 in CLEAR, so the accumulator zeroes.
- CLEAR (1 cycle) -> HIGH with sequence 0 and phase counter 0.
- HIGH: oProcessing=1, oClockLevel=1. After HALF_PERIOD cycles go to LOW.
- LOW: oProcessing=1, oClockLevel=0. After HALF_PERIOD cycles:
  - if the sequence is NUM_SEQUENCES-1, go to SUM;
  - otherwise increment the sequence and go to HIGH.
- SUM (1 cycle): oProcessing=0, oKeepResult=1. Register oTotalError = Σ over k with mask[k]=1 of zero-extended iErrorSums[k], in 35-bit unsigned arithmetic with no overflow possible. Go to DONE.
- DONE: oKeepResult=1; oDone high only on the first DONE cycle. Stay in DONE until iStart.
- IDLE: oKeepResult=0; oProcessing=0; oClockLevel=0; oCurrentSequence=0.
- iAbort in CLEAR/HIGH/LOW/SUM: go to IDLE next cycle. oTotalError is unchanged and oDone is not pulsed. iAbort has priority over every other transition; it is ignored in IDLE/DONE.
- iStart while busy is ignored; there is no queueing.
- iStart and iAbort together in DONE: start wins.
- oCurrentSequence changes only on a LOW->HIGH transition, never mid-phase.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Start sampled at edge E0: CLEAR is visible E0..E1; first HIGH cycle at E1; SUM entered at E1 + 2·HALF_PERIOD·NUM_SEQUENCES.
- oDone and the new oTotalError appear 1 cycle after SUM entry, i.e. 2 + 2·HALF_PERIOD·NUM_SEQUENCES cycles after E0.
- oProcessing is high during exactly 2·HALF_PERIOD·NUM_SEQUENCES consecutive cycles. The accumulator's last update is on the edge ending the final LOW cycle, so iErrorSums are final during SUM.
- Each sequence holds exactly 2·HALF_PERIOD cycles, and a falling edge of oClockLevel occurs exactly once per sequence.
- Back-to-back: iStart in the oDone cycle enters CLEAR next cycle, giving a 1-cycle gap between evaluations.

## Test plan
- Reset mid-HIGH of sequence 5: all outputs 0 immediately (async), and the block stays in IDLE until a start -> then a full evaluation completes normally.
- HALF_PERIOD=4, NUM_SEQUENCES=16, mask 0xFF, accumulator model fed a constant circuit output 0x00 against expected 0xFF with ignore window 0 -> each sum is 128, oTotalError=1024, oDone exactly 130 cycles after start.
- Same stimulus with mask 0x05 -> oTotalError=256; mask 0x00 -> oTotalError=0 with oDone still pulsed.
- Forced iErrorSums all 0xFFFFFFFF, mask 0xFF -> oTotalError=0x7_FFFF_FFF8 with no wrap.
- iAbort in sequence 9 LOW -> IDLE next cycle, no oDone, previous oTotalError retained; iStart in the same run -> ignored while busy.
- Check oClockLevel/oCurrentSequence waveforms: 16 falling edges per run, sequence index 0..15 each held 2·HALF_PERIOD cycles. Then iStart in the oDone cycle -> CLEAR with oKeepResult=0 on the next cycle.
